// File: rtl/frac_div_ctrl.sv
// frac_div_ctrl: fractional pulse generator (DST pulses per SRC clocks) with a valid/ready ratio controller
module frac_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int SRC_DEF = 76,
  parameter int DST_DEF = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_src,
  input  logic [CNT_W-1:0] cfg_dst,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             clk_frac,
  output logic [CNT_W-1:0] act_src,
  output logic [CNT_W-1:0] act_dst
);
  typedef enum logic [1:0] {C_IDLE, C_CALC, C_PEND} state_t;
  localparam int SW = $clog2(CNT_W);
  localparam logic [CNT_W-1:0] SRC_D = CNT_W'(SRC_DEF);
  localparam logic [CNT_W-1:0] DST_D = CNT_W'(DST_DEF);
  localparam logic [CNT_W-1:0] Q_D   = CNT_W'(SRC_DEF / DST_DEF);
  localparam logic [CNT_W-1:0] R_D   = CNT_W'(SRC_DEF % DST_DEF);
  state_t           state;
  logic [CNT_W-1:0] q, r, dst, cnt, new_src, new_dst, quo, rem;
  logic [CNT_W:0]   acc, sum, sum_mod, trial;
  logic [SW-1:0]    step;
  logic             ge, last, tge, illegal, apply;
  assign sum     = acc + {1'b0, r};
  assign ge      = sum >= {1'b0, dst};
  assign sum_mod = ge ? sum - {1'b0, dst} : sum;
  // period length is q+ge, so the final counter value is q+ge-1
  assign last    = ({1'b0, cnt} + (CNT_W+1)'(1)) == ({1'b0, q} + (CNT_W+1)'(ge));
  assign trial   = {rem, quo[CNT_W-1]};
  assign tge     = trial >= {1'b0, new_dst};
  assign illegal = (cfg_dst == '0) || (cfg_dst > cfg_src);
  assign apply   = (state == C_PEND) && (!en || last);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= C_IDLE;
      cfg_ready <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      clk_frac  <= 1'b0;
      act_src   <= SRC_D;
      act_dst   <= DST_D;
      q         <= Q_D;
      r         <= R_D;
      dst       <= DST_D;
      cnt       <= '0;
      acc       <= '0;
      new_src   <= '0;
      new_dst   <= '0;
      quo       <= '0;
      rem       <= '0;
      step      <= '0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      cnt      <= !en ? '0 : last ? '0 : cnt + 1'b1;
      acc      <= !en ? '0 : last ? sum_mod : acc;
      clk_frac <= en && last;
      case (state)
        C_IDLE: if (cfg_valid) begin
          if (illegal) cfg_err <= 1'b1;
          else begin
            new_src   <= cfg_src;
            new_dst   <= cfg_dst;
            quo       <= cfg_src;
            rem       <= '0;
            step      <= '0;
            cfg_ready <= 1'b0;
            state     <= C_CALC;
          end
        end
        C_CALC: begin
          quo   <= {quo[CNT_W-2:0], tge};
          rem   <= tge ? CNT_W'(trial - {1'b0, new_dst}) : trial[CNT_W-1:0];
          step  <= step + 1'b1;
          state <= (step == SW'(CNT_W-1)) ? C_PEND : C_CALC;
        end
        C_PEND: if (apply) begin
          // the in-flight period has just finished with the old ratio
          q         <= quo;
          r         <= rem;
          dst       <= new_dst;
          act_src   <= new_src;
          act_dst   <= new_dst;
          acc       <= '0;
          cnt       <= '0;
          cfg_done  <= 1'b1;
          cfg_ready <= 1'b1;
          state     <= C_IDLE;
        end
        default: state <= C_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frac_div_ctrl.sv
// tb_frac_div_ctrl: randomized scoreboard bench; pulse k of a segment is expected at edge floor(k*SRC/DST)
module tb_frac_div_ctrl;
  logic clk = 0, rstn = 0, en = 0, cfg_valid = 0;
  logic [7:0] cfg_src = 0, cfg_dst = 0;
  logic cfg_ready, cfg_done, cfg_err, clk_frac;
  logic [7:0] act_src, act_dst;
  frac_div_ctrl #(.CNT_W(8), .SRC_DEF(76), .DST_DEF(10)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .clk_frac(clk_frac), .act_src(act_src), .act_dst(act_dst));
  always #5 clk = ~clk;
  typedef struct packed {
    logic f, d, e, r;
    logic [7:0] s, t;
  } rec_t;
  localparam rec_t RST_REC = '{f: 1'b0, d: 1'b0, e: 1'b0, r: 1'b1, s: 8'd76, t: 8'd10};
  rec_t sb[$];
  int checks = 0, errors = 0, dones = 0;
  int m_src = 76, m_dst = 10, t = 0, k = 0, ms = 0, calc = 0, n_src = 0, n_dst = 0;
  rec_t x;
  logic p;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_src = 76; m_dst = 10; t = 0; k = 0; ms = 0; calc = 0;
      sb.delete();
    end else begin
      p = en && (t + 1 == ((k + 1) * m_src) / m_dst);
      if (!en) begin
        t = 0; k = 0;
      end else begin
        t = t + 1;
        if (p) k = k + 1;
        if (k == m_dst) begin t = 0; k = 0; end
      end
      x = '0;
      x.f = p;
      if (ms == 0) begin
        if (cfg_valid) begin
          if (cfg_dst == 0 || cfg_dst > cfg_src) x.e = 1'b1;
          else begin n_src = cfg_src; n_dst = cfg_dst; calc = 8; ms = 1; end
        end
      end else if (ms == 1) begin
        calc = calc - 1;
        if (calc == 0) ms = 2;
      end else if (!en || p) begin
        m_src = n_src; m_dst = n_dst; t = 0; k = 0; x.d = 1'b1; ms = 0;
      end
      x.r = (ms == 0);
      x.s = 8'(m_src);
      x.t = 8'(m_dst);
      sb.push_back(x);
    end
  end
  rec_t a, e;
  always @(negedge clk) begin
    a = '{f: clk_frac, d: cfg_done, e: cfg_err, r: cfg_ready, s: act_src, t: act_dst};
    e = (sb.size() > 0) ? sb.pop_front() : RST_REC;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs @%0t: got frac=%b done=%b err=%b ready=%b src=%0d dst=%0d, want frac=%b done=%b err=%b ready=%b src=%0d dst=%0d",
               $time, a.f, a.d, a.e, a.r, a.s, a.t, e.f, e.d, e.e, e.r, e.s, e.t);
    end
    if (cfg_done) dones++;
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic req(input int s, input int d);
    logic rd;
    cfg_src = 8'(s); cfg_dst = 8'(d); cfg_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk) rd = cfg_ready;
      @(posedge clk); #2;
      if (rd) begin cfg_valid = 1'b0; return; end
    end
    cfg_valid = 1'b0;
    checks++; errors++;
    $display("FAIL handshake timeout: got no cfg_ready, want cfg_ready within 600 cycles");
  endtask
  int d0, s, d;
  initial begin
    cyc(3);
    rstn = 1; en = 1;
    cyc(160);
    req(25, 4);
    cyc(80);
    req(77, 0); cyc(5); req(10, 11);
    cyc(40);
    en = 0; req(5, 5); cyc(12);
    en = 1; cyc(15);
    d0 = dones;
    req(76, 10); req(30, 7);
    cyc(100);
    checks++;
    if (dones - d0 != 2) begin
      errors++;
      $display("FAIL done_count: got %0d, want 2", dones - d0);
    end
    req(250, 2); cyc(12); en = 0; cyc(4); en = 1;
    cyc(10);
    req(40, 3); cyc(3); rstn = 0; cyc(2); rstn = 1;
    cyc(30);
    cyc(3); rstn = 0; cyc(1); rstn = 1;
    cyc(20);
    for (int i = 0; i < 25; i++) begin
      en = ($urandom_range(0, 4) != 0);
      s = $urandom_range(1, 120);
      d = $urandom_range(0, s + 2);
      req(s, d);
      cyc($urandom_range(0, 60));
    end
    en = 1;
    cyc(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
